// File: rtl/elm_inference_sequencer.sv
// Control sequencer for one ELM inference pass: image capture, hidden-layer release,
// output-layer start, result handshake, and a watchdog that parks the block on a hang.
module elm_inference_sequencer #(
    parameter int unsigned IMG_BITS = 256,
    parameter int unsigned LABEL_W  = 4,
    parameter int unsigned TIMEOUT  = 100000
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                img_valid,
    input  logic [1:IMG_BITS]   img_data,
    output logic                img_ready,
    output logic [1:IMG_BITS]   hl_image,
    output logic                hl_restart,
    input  logic                hl_update,
    output logic                ol_start,
    input  logic                ol_done,
    input  logic [LABEL_W-1:0]  ol_class,
    output logic                res_valid,
    output logic [LABEL_W-1:0]  res_class,
    input  logic                res_ready,
    output logic                busy,
    output logic                timeout_err,
    output logic [15:0]         img_count
);

    localparam int unsigned     WD_W       = 17;
    localparam logic [WD_W-1:0] WD_TIMEOUT = WD_W'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        HL_RUN,
        OL_WAIT,
        RESULT,
        ERROR
    } state_t;

    state_t              state, state_nxt;
    logic [WD_W-1:0]     wd, wd_nxt, wd_inc;
    logic [1:IMG_BITS]   hl_image_nxt;
    logic [LABEL_W-1:0]  res_class_nxt;
    logic [15:0]         img_count_nxt;
    logic                ol_start_nxt;
    logic                wd_expired;

    function automatic logic [WD_W-1:0] sat_inc(input logic [WD_W-1:0] v);
        return (v == {WD_W{1'b1}}) ? v : v + WD_W'(1);
    endfunction

    // wd_inc is the count including the edge now being taken, so the TIMEOUT-th
    // edge in a state is the one that moves to ERROR.
    assign wd_inc     = sat_inc(wd);
    assign wd_expired = (wd_inc >= WD_TIMEOUT);

    always_comb begin
        state_nxt     = state;
        wd_nxt        = '0;
        hl_image_nxt  = hl_image;
        res_class_nxt = res_class;
        img_count_nxt = img_count;
        ol_start_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (img_valid && img_ready) begin
                    hl_image_nxt = img_data;
                    state_nxt    = HL_RUN;
                end
            end
            HL_RUN: begin
                if (hl_update) begin
                    ol_start_nxt = 1'b1;
                    state_nxt    = OL_WAIT;
                end else if (wd_expired) begin
                    state_nxt = ERROR;
                end else begin
                    wd_nxt = wd_inc;
                end
            end
            OL_WAIT: begin
                // A result arriving on the expiry edge still wins over the watchdog.
                if (ol_done) begin
                    res_class_nxt = ol_class;
                    state_nxt     = RESULT;
                end else if (wd_expired) begin
                    state_nxt = ERROR;
                end else begin
                    wd_nxt = wd_inc;
                end
            end
            RESULT: begin
                if (res_valid && res_ready) begin
                    img_count_nxt = img_count + 16'd1;
                    state_nxt     = IDLE;
                end
            end
            ERROR: begin
                state_nxt = ERROR;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Every output is a register derived from the next state, so nothing combinational
    // reaches the layer or handshake pins.
    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            wd          <= '0;
            img_ready   <= 1'b1;
            hl_restart  <= 1'b1;
            hl_image    <= '0;
            ol_start    <= 1'b0;
            res_valid   <= 1'b0;
            res_class   <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            img_count   <= '0;
        end else begin
            state       <= state_nxt;
            wd          <= wd_nxt;
            img_ready   <= (state_nxt == IDLE);
            hl_restart  <= (state_nxt == IDLE) || (state_nxt == ERROR);
            hl_image    <= hl_image_nxt;
            ol_start    <= ol_start_nxt;
            res_valid   <= (state_nxt == RESULT);
            res_class   <= res_class_nxt;
            busy        <= (state_nxt != IDLE);
            timeout_err <= (state_nxt == ERROR);
            img_count   <= img_count_nxt;
        end
    end

endmodule

// File: tb/tb_elm_inference_sequencer.sv
// Directed bench for elm_inference_sequencer: a default-timeout instance for the
// functional passes and a TIMEOUT=100 instance for the watchdog cases.
module tb_elm_inference_sequencer;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         img_valid = 1'b0;
    logic [1:256] img_data = '0;
    logic         hl_update = 1'b0;
    logic         ol_done = 1'b0;
    logic [3:0]   ol_class = '0;
    logic         res_ready = 1'b0;

    logic         img_ready, hl_restart, ol_start, res_valid, busy, timeout_err;
    logic [1:256] hl_image;
    logic [3:0]   res_class;
    logic [15:0]  img_count;

    logic         t_img_ready, t_hl_restart, t_ol_start, t_res_valid, t_busy, t_timeout_err;
    logic [1:256] t_hl_image;
    logic [3:0]   t_res_class;
    logic [15:0]  t_img_count;

    int tests = 0;
    int fails = 0;

    localparam logic [1:256] PAT_A5 = {32{8'hA5}};
    localparam logic [1:256] PAT_3C = {32{8'h3C}};
    localparam logic [1:256] PAT_FF = {32{8'hFF}};

    always #5 clock = ~clock;

    elm_inference_sequencer dut (
        .clock(clock), .reset(reset), .img_valid(img_valid), .img_data(img_data),
        .img_ready(img_ready), .hl_image(hl_image), .hl_restart(hl_restart),
        .hl_update(hl_update), .ol_start(ol_start), .ol_done(ol_done), .ol_class(ol_class),
        .res_valid(res_valid), .res_class(res_class), .res_ready(res_ready),
        .busy(busy), .timeout_err(timeout_err), .img_count(img_count)
    );

    elm_inference_sequencer #(.TIMEOUT(100)) dut_t (
        .clock(clock), .reset(reset), .img_valid(img_valid), .img_data(img_data),
        .img_ready(t_img_ready), .hl_image(t_hl_image), .hl_restart(t_hl_restart),
        .hl_update(hl_update), .ol_start(t_ol_start), .ol_done(ol_done), .ol_class(ol_class),
        .res_valid(t_res_valid), .res_class(t_res_class), .res_ready(res_ready),
        .busy(t_busy), .timeout_err(t_timeout_err), .img_count(t_img_count)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tests++; if (img_ready !== 1'b1) begin fails++; $display("FAIL reset_img_ready got %0b want 1", img_ready); end
        tests++; if (hl_restart !== 1'b1) begin fails++; $display("FAIL reset_hl_restart got %0b want 1", hl_restart); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %0b want 0", busy); end
        tests++; if (img_count !== 16'd0) begin fails++; $display("FAIL reset_img_count got %0d want 0", img_count); end
        tests++; if (res_valid !== 1'b0) begin fails++; $display("FAIL reset_res_valid got %0b want 0", res_valid); end
        tests++; if (hl_image !== '0) begin fails++; $display("FAIL reset_hl_image got %h want 0", hl_image); end
        tests++; if (ol_start !== 1'b0 || timeout_err !== 1'b0 || res_class !== 4'd0) begin
            fails++; $display("FAIL reset_misc got ol_start=%0b timeout_err=%0b res_class=%0d want 0/0/0", ol_start, timeout_err, res_class);
        end
    endtask

    task automatic test_nominal();
        int bad;
        res_ready = 1'b1;
        img_data  = PAT_A5;
        img_valid = 1'b1;
        tick();
        img_valid = 1'b0;
        img_data  = '0;
        tests++; if (hl_image !== PAT_A5) begin fails++; $display("FAIL nom_hl_image got %h want %h", hl_image, PAT_A5); end
        tests++; if (hl_restart !== 1'b0 || img_ready !== 1'b0 || busy !== 1'b1) begin
            fails++; $display("FAIL nom_accept got restart=%0b ready=%0b busy=%0b want 0/0/1", hl_restart, img_ready, busy);
        end
        bad = 0;
        for (int i = 0; i < 77399; i++) begin
            tick();
            if (ol_start !== 1'b0 || res_valid !== 1'b0 || timeout_err !== 1'b0 || busy !== 1'b1) bad++;
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL nom_hl_wait got %0d bad cycles want 0", bad); end
        hl_update = 1'b1;
        tick();
        tests++; if (ol_start !== 1'b1) begin fails++; $display("FAIL nom_ol_start_rise got %0b want 1", ol_start); end
        tick();
        hl_update = 1'b0;
        tests++; if (ol_start !== 1'b0) begin fails++; $display("FAIL nom_ol_start_fall got %0b want 0", ol_start); end
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (ol_start !== 1'b0 || res_valid !== 1'b0) bad++;
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL nom_ol_wait got %0d bad cycles want 0", bad); end
        ol_done  = 1'b1;
        ol_class = 4'd7;
        tick();
        ol_done  = 1'b0;
        ol_class = 4'd0;
        tests++; if (res_valid !== 1'b1 || res_class !== 4'd7) begin
            fails++; $display("FAIL nom_result got valid=%0b class=%0d want 1/7", res_valid, res_class);
        end
        tests++; if (hl_restart !== 1'b0) begin fails++; $display("FAIL nom_result_restart got %0b want 0", hl_restart); end
        tick();
        tests++; if (res_valid !== 1'b0 || img_count !== 16'd1) begin
            fails++; $display("FAIL nom_handshake got valid=%0b count=%0d want 0/1", res_valid, img_count);
        end
        tests++; if (img_ready !== 1'b1 || hl_restart !== 1'b1 || busy !== 1'b0) begin
            fails++; $display("FAIL nom_idle got ready=%0b restart=%0b busy=%0b want 1/1/0", img_ready, hl_restart, busy);
        end
        res_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        res_ready = 1'b0;
        img_data  = PAT_3C;
        img_valid = 1'b1;
        tick();
        img_data  = PAT_FF;
        hl_update = 1'b1;
        tick();
        hl_update = 1'b0;
        ol_done   = 1'b1;
        ol_class  = 4'h9;
        tick();
        ol_done   = 1'b0;
        ol_class  = 4'h2;
        for (int i = 0; i < 20; i++) begin
            tests++; if (res_valid !== 1'b1 || res_class !== 4'h9) begin
                fails++; $display("FAIL bp_hold[%0d] got valid=%0b class=%0d want 1/9", i, res_valid, res_class);
            end
            tests++; if (img_ready !== 1'b0 || hl_image !== PAT_3C) begin
                fails++; $display("FAIL bp_no_capture[%0d] got ready=%0b image=%h want 0/%h", i, img_ready, hl_image, PAT_3C);
            end
            tick();
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        tests++; if (res_valid !== 1'b0 || img_ready !== 1'b1 || img_count !== 16'd2 || hl_image !== PAT_3C) begin
            fails++; $display("FAIL bp_release got valid=%0b ready=%0b count=%0d image=%h want 0/1/2/%h", res_valid, img_ready, img_count, hl_image, PAT_3C);
        end
        tick();
        img_valid = 1'b0;
        tests++; if (hl_image !== PAT_FF || busy !== 1'b1 || img_ready !== 1'b0) begin
            fails++; $display("FAIL bp_next_image got image=%h busy=%0b ready=%0b want %h/1/0", hl_image, busy, img_ready, PAT_FF);
        end
    endtask

    task automatic test_spurious();
        ol_done  = 1'b1;
        ol_class = 4'd5;
        tick();
        ol_done  = 1'b0;
        tests++; if (busy !== 1'b1 || res_valid !== 1'b0 || ol_start !== 1'b0 || hl_restart !== 1'b0) begin
            fails++; $display("FAIL sp_done_in_hl got busy=%0b valid=%0b start=%0b restart=%0b want 1/0/0/0", busy, res_valid, ol_start, hl_restart);
        end
        hl_update = 1'b1;
        tick();
        tests++; if (ol_start !== 1'b1) begin fails++; $display("FAIL sp_start got %0b want 1", ol_start); end
        tick();
        hl_update = 1'b0;
        tick();
        hl_update = 1'b1;
        tick();
        hl_update = 1'b0;
        tests++; if (ol_start !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b1) begin
            fails++; $display("FAIL sp_update_in_ol got start=%0b valid=%0b busy=%0b want 0/0/1", ol_start, res_valid, busy);
        end
        ol_done  = 1'b1;
        ol_class = 4'd5;
        tick();
        ol_done  = 1'b0;
        tests++; if (res_valid !== 1'b1 || res_class !== 4'd5) begin
            fails++; $display("FAIL sp_result got valid=%0b class=%0d want 1/5", res_valid, res_class);
        end
        res_ready = 1'b1;
        tick();
        tests++; if (img_count !== 16'd3 || res_valid !== 1'b0) begin
            fails++; $display("FAIL sp_complete got count=%0d valid=%0b want 3/0", img_count, res_valid);
        end
        tick();
        res_ready = 1'b0;
        tests++; if (img_count !== 16'd3 || busy !== 1'b0) begin
            fails++; $display("FAIL sp_ready_idle got count=%0d busy=%0b want 3/0", img_count, busy);
        end
    endtask

    task automatic test_timeout();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        img_data  = PAT_A5;
        img_valid = 1'b1;
        tick();
        img_valid = 1'b0;
        repeat (99) tick();
        tests++; if (t_timeout_err !== 1'b0 || t_busy !== 1'b1) begin
            fails++; $display("FAIL to_edge99 got err=%0b busy=%0b want 0/1", t_timeout_err, t_busy);
        end
        tick();
        tests++; if (t_timeout_err !== 1'b1 || t_hl_restart !== 1'b1 || t_img_ready !== 1'b0 || t_res_valid !== 1'b0) begin
            fails++; $display("FAIL to_edge100 got err=%0b restart=%0b ready=%0b valid=%0b want 1/1/0/0", t_timeout_err, t_hl_restart, t_img_ready, t_res_valid);
        end
        img_valid = 1'b1;
        ol_done   = 1'b1;
        ol_class  = 4'd3;
        hl_update = 1'b1;
        repeat (5) tick();
        img_valid = 1'b0;
        ol_done   = 1'b0;
        hl_update = 1'b0;
        tests++; if (t_timeout_err !== 1'b1 || t_img_ready !== 1'b0 || t_res_valid !== 1'b0 || t_ol_start !== 1'b0 || t_img_count !== 16'd0 || t_hl_image !== PAT_A5) begin
            fails++; $display("FAIL to_sticky got err=%0b ready=%0b valid=%0b start=%0b count=%0d want 1/0/0/0/0", t_timeout_err, t_img_ready, t_res_valid, t_ol_start, t_img_count);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests++; if (t_timeout_err !== 1'b0 || t_img_ready !== 1'b1 || t_busy !== 1'b0 || t_hl_image !== '0) begin
            fails++; $display("FAIL to_reset_exit got err=%0b ready=%0b busy=%0b want 0/1/0", t_timeout_err, t_img_ready, t_busy);
        end
    endtask

    task automatic test_timeout_race();
        img_data  = PAT_3C;
        img_valid = 1'b1;
        tick();
        img_valid = 1'b0;
        hl_update = 1'b1;
        tick();
        hl_update = 1'b0;
        tests++; if (t_ol_start !== 1'b1) begin fails++; $display("FAIL race_start got %0b want 1", t_ol_start); end
        repeat (99) tick();
        tests++; if (t_res_valid !== 1'b0 || t_timeout_err !== 1'b0) begin
            fails++; $display("FAIL race_edge99 got valid=%0b err=%0b want 0/0", t_res_valid, t_timeout_err);
        end
        ol_done  = 1'b1;
        ol_class = 4'hC;
        tick();
        ol_done  = 1'b0;
        tests++; if (t_res_valid !== 1'b1 || t_res_class !== 4'hC || t_timeout_err !== 1'b0) begin
            fails++; $display("FAIL race_done_wins got valid=%0b class=%0d err=%0b want 1/12/0", t_res_valid, t_res_class, t_timeout_err);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        tests++; if (t_img_count !== 16'd1 || t_img_ready !== 1'b1) begin
            fails++; $display("FAIL race_complete got count=%0d ready=%0b want 1/1", t_img_count, t_img_ready);
        end
    endtask

    task automatic test_midrun_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        img_data  = PAT_FF;
        img_valid = 1'b1;
        tick();
        img_valid = 1'b0;
        hl_update = 1'b1;
        tick();
        hl_update = 1'b0;
        tests++; if (ol_start !== 1'b1 || busy !== 1'b1) begin
            fails++; $display("FAIL mr_in_ol_wait got start=%0b busy=%0b want 1/1", ol_start, busy);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests++; if (img_ready !== 1'b1 || hl_restart !== 1'b1 || hl_image !== '0 || busy !== 1'b0) begin
            fails++; $display("FAIL mr_reset_a got ready=%0b restart=%0b busy=%0b image=%h want 1/1/0/0", img_ready, hl_restart, busy, hl_image);
        end
        tests++; if (ol_start !== 1'b0 || res_valid !== 1'b0 || res_class !== 4'd0 || img_count !== 16'd0 || timeout_err !== 1'b0) begin
            fails++; $display("FAIL mr_reset_b got start=%0b valid=%0b class=%0d count=%0d err=%0b want all 0", ol_start, res_valid, res_class, img_count, timeout_err);
        end
    endtask

    task automatic test_wrap();
        force dut.img_count = 16'hFFFF;
        repeat (2) tick();
        release dut.img_count;
        img_data  = PAT_A5;
        img_valid = 1'b1;
        tick();
        img_valid = 1'b0;
        hl_update = 1'b1;
        tick();
        hl_update = 1'b0;
        ol_done   = 1'b1;
        ol_class  = 4'd1;
        tick();
        ol_done   = 1'b0;
        tests++; if (img_count !== 16'hFFFF || res_valid !== 1'b1) begin
            fails++; $display("FAIL wrap_pre got count=%0d valid=%0b want 65535/1", img_count, res_valid);
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        tests++; if (img_count !== 16'd0 || img_ready !== 1'b1) begin
            fails++; $display("FAIL wrap_zero got count=%0d ready=%0b want 0/1", img_count, img_ready);
        end
    endtask

    initial begin
        tick();
        test_reset();
        test_nominal();
        test_backpressure();
        test_spurious();
        test_timeout();
        test_timeout_race();
        test_midrun_reset();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/elm_inference_sequencer.md
# elm_inference_sequencer

Top-level sequencer for one ELM inference pass. Accepts a 256-bit binary image over a valid/ready handshake and holds it stable for the first hidden layer. Releases and re-arms the hidden layer through its synchronous reset, starts the output layer on the hidden layer's `update` pulse, and returns the class label over a valid/ready result handshake. A watchdog flags a hung layer.

## Interface
- `IMG_BITS`, 256, image width; matches hidden-layer `image_data`.
- `LABEL_W`, 4, class label width.
- `TIMEOUT`, 100000, max cycles allowed in HL_RUN or OL_WAIT; watchdog counter is 17 bits.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `img_valid` in 1: image source has data.
- `img_data` in IMG_BITS: image, bit 1 first (`[1:IMG_BITS]`).
- `img_ready` out 1: sequencer can accept an image.
- `hl_image` out IMG_BITS: registered image driven to hidden layer `image_data`.
- `hl_restart` out 1: drives hidden layer `reset`; high holds that layer idle.
- `hl_update` in 1: hidden layer `update`; may stay high for several cycles.
- `ol_start` out 1: one-cycle start pulse to the output layer.
- `ol_done` in 1: output layer result strobe.
- `ol_class` in LABEL_W: output layer label, valid with `ol_done`.
- `res_valid` out 1, `res_class` out LABEL_W, `res_ready` in 1: result handshake.
- `busy` out 1: state is not IDLE.
- `timeout_err` out 1: sticky watchdog error.
- `img_count` out 16: completed inferences; wraps at 65535→0.

## Operation
- States: IDLE, HL_RUN, OL_WAIT, RESULT, ERROR. All outputs are registered.
- **IDLE**
  - `img_ready`=1 and `hl_restart`=1.
  - On `img_valid`&&`img_ready`, capture `img_data` into `hl_image`, clear the watchdog, and go to HL_RUN.
- **HL_RUN**
  - `hl_restart`=0.
  - On the first cycle `hl_update`=1, go to OL_WAIT, assert `ol_start` for exactly one cycle, and clear the watchdog.
  - `ol_done` is ignored in this state.
- **OL_WAIT**
  - On `ol_done`, latch `ol_class` into `res_class`, set `res_valid`=1, and go to RESULT.
  - Further `hl_update` activity is ignored.
- **RESULT**
  - `res_valid` holds, and `res_class` stays stable, until `res_ready`.
  - On the handshake: clear `res_valid`, increment `img_count`, and go to IDLE.
  - `hl_restart` stays 0 so the hidden layer's `Hidden` vector is preserved.
- **ERROR**
  - Entered when the watchdog reaches TIMEOUT in HL_RUN or OL_WAIT.
  - Sets `timeout_err`=1, `hl_restart`=1, `img_ready`=0, `res_valid`=0.
  - Only `reset` exits this state.
- Watchdog behaviour:
  - Increments each cycle in HL_RUN and OL_WAIT.
  - Holds at 0 in all other states.
  - Saturates; it never wraps.
- `hl_image` changes only at image acceptance.
- `img_valid` outside IDLE is not accepted, and no data is lost because `img_ready`=0.
- `ol_done` outside OL_WAIT is dropped.
- `res_ready` while `res_valid`=0 has no effect.

## Timing
- Reset values:
  - state IDLE
  - `img_ready`=1, `hl_restart`=1, `hl_image`=0
  - `ol_start`=0, `res_valid`=0, `res_class`=0
  - `busy`=0, `timeout_err`=0, `img_count`=0, watchdog=0
- Reset mid-operation aborts the pass, and every output takes its reset value on the next edge.
- Image accepted at edge k:
  - `hl_image` is new and `hl_restart` falls after edge k.
  - The hidden layer samples `hl_restart`=1 at edge k and starts clean with the new image.
- `hl_update` sampled high at edge m: `ol_start`=1 for cycle m..m+1 only.
- `ol_done` sampled at edge n: `res_valid`=1 and `res_class` are valid after edge n.
- `res_valid` and `res_ready` both high at edge p: `res_valid`=0, `img_ready`=1 and `hl_restart`=1 after edge p. A new image can be accepted at edge p+1.
- Watchdog timeout: with the watchdog cleared at state entry, `timeout_err` asserts at the TIMEOUT-th edge spent in the state. `ol_done` arriving on that same edge wins, so the result is taken.
- `busy`=0 only in IDLE.

## Test plan
- **Reset:** hold `reset` 3 cycles -> `img_ready`=1, `hl_restart`=1, `busy`=0, `img_count`=0, `res_valid`=0.
- **Nominal pass:** present image 256'h...A5 with `img_valid`=1. Raise `hl_update` for 2 cycles at cycle 77400. Pulse `ol_done` with `ol_class`=7 after 50 cycles. Hold `res_ready`=1. Required: `hl_image`=A5 pattern, `ol_start` high exactly 1 cycle, `res_class`=7, `img_count`=1, back in IDLE.
- **Backpressure:** hold `res_ready`=0 for 20 cycles after `res_valid` rises, and drive `img_valid`=1 throughout -> `res_class` is stable, `img_ready`=0, no second image is captured. Raise `res_ready` -> the next image is accepted on the following edge.
- **Spurious inputs:** pulse `ol_done` in HL_RUN and `hl_update` in OL_WAIT -> no state change and no extra `ol_start`.
- **Timeout:** set TIMEOUT=100 and never assert `hl_update` -> `timeout_err`=1 after 100 cycles in HL_RUN, `hl_restart`=1, `img_ready`=0. Further `img_valid` and `ol_done` are ignored until `reset`.
- **Mid-run reset and wrap:** assert `reset` during OL_WAIT -> all reset values on the next edge. Separately preload `img_count` to 65535 via 65535 passes with a short-latency layer model -> the next completion gives `img_count`=0.
